regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Round-robin arbiter that shares the register-file write port between four write-back requesters. It owns the select of the 4:1 5-bit destination-register multiplexer and registers the winning address, data and write enable toward the register file. Requesters use a hold-until-grant handshake. A stall input freezes arbitration for pipeline hazards.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register-address width; fixed at 5 for the 32-entry register file
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  high: no grant issued this cycle
- req  in  4  per-requester write request; bit i = requester i
- addr0..addr3  in  ADDR_W each  destination register of requester i
- data0..data3  in  DATA_W each  write data of requester i
- gnt  out  4  one-hot grant; combinational from req, stall and the priority pointer
- sel  out  2  registered mux select; index of the last accepted requester
- wr_en  out  1  registered register-file write enable
- wr_addr  out  ADDR_W  registered write address
- wr_data  out  DATA_W  registered write data

## Operation
- Priority pointer ptr (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- gnt = one-hot of the first requester in search order with req set. gnt = 0 when stall=1, when req=0, or while rst_n=0.
- A transfer on port i happens in a cycle where gnt[i]=1 at the rising edge.
- Requester i must hold req[i], addr_i and data_i stable until it sees gnt[i]=1. It may drop req[i] in the cycle after the grant.
- On a transfer from port i:
  - sel <= i
  - wr_addr <= addr_i
  - wr_data <= data_i
  - wr_en <= 1, except wr_en <= 0 when addr_i == 0, because $zero is never written
  - ptr <= (i+1) mod 4
- With no transfer: wr_en <= 0. sel, wr_addr, wr_data and ptr hold.
- Fairness: with stall low, a continuously held request is granted within 4 cycles of being raised.
- ADDR_W and DATA_W values pass through unmodified. There is no arithmetic except the mod-4 pointer increment, which wraps from 3 to 0.

## Timing
- Reset (rst_n low, asynchronous) sets sel=0, wr_en=0, wr_addr=0, wr_data=0, ptr=0. gnt is forced to 0 for the whole time rst_n is low.
- If rst_n asserts in the same cycle as a grant, the transfer is discarded and the requester must re-request.
- Grant-to-write latency is 1 cycle: a grant at edge N makes wr_en/wr_addr/wr_data/sel valid from edge N until edge N+1.
- The register file samples the write on edge N+1.
- Throughput is one transfer per cycle. Back-to-back grants to different ports are allowed.
- A lone requester holding req is granted every cycle.
- stall rising: gnt=0 in the same cycle. wr_en drops to 0 at the next edge. ptr freezes.
- stall falling: arbitration resumes from the frozen ptr.
- Simultaneous requests: exactly one grant per cycle, never more than one gnt bit high.
- A req change takes effect combinationally in the same cycle.

## Test plan
- Reset:
  - Drive rst_n low mid-transfer with req=4'b1111 -> gnt=0, wr_en=0, sel=0, wr_addr=0 immediately and with no clock edge.
  - Release rst_n -> first grant gnt=4'b0001.
- Round robin:
  - Hold req=4'b1111 with addr_i = i+1 for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001 and onward.
  - wr_addr sequence 1, 2, 3, 4, 1, each value one cycle after its grant, with sel tracking the granted index.
- Wrap and skip:
  - After a grant to port 3, set req=4'b0101 -> grant port 0 first, then port 2, then port 0.
- Zero register:
  - req[1]=1, addr1=0, data1=0xDEADBEEF -> gnt=4'b0010 and ptr advances.
  - Next cycle wr_en=0, wr_addr=0, wr_data=0xDEADBEEF, sel=1.
- Stall:
  - With req=4'b0110, raise stall for 3 cycles -> gnt=0 and wr_en=0 throughout.
  - On stall release, port 1 is granted first (ptr unchanged), then port 2.
- Single requester:
  - req=4'b1000 held with data3 = 0, 1, 2 on successive cycles -> gnt[3]=1 every cycle.
  - wr_data = 0, 1, 2 with one cycle of lag and wr_en held at 1.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Round-robin arbiter sharing the single register-file write port between
// four write-back requesters. The winner's destination address and data are
// captured into registers that drive the register file one cycle after the
// grant. Writes to register 0 are suppressed because $zero is hard-wired.
//
// Ports:
//   clk              system clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   stall            high blocks all grants this cycle and freezes priority
//   req[3:0]         per-requester write request (hold until granted)
//   addr0..addr3     destination register of each requester
//   data0..data3     write data of each requester
//   gnt[3:0]         combinational one-hot grant
//   sel[1:0]         registered index of the last accepted requester
//   wr_en            registered register-file write enable
//   wr_addr          registered write address
//   wr_data          registered write data

module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [1:0]        ptr;
  logic [1:0]        cand;
  logic [1:0]        win;
  logic              found;
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];

  assign addr_arr[0] = addr0;
  assign addr_arr[1] = addr1;
  assign addr_arr[2] = addr2;
  assign addr_arr[3] = addr3;
  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;
  assign data_arr[3] = data3;

  // Walk the requesters starting at the priority pointer; the 2-bit add
  // wraps naturally so the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
  // Reset and stall veto the winner so nothing is granted while either holds.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (!rst_n || stall) begin
      found = 1'b0;
    end
  end

  assign gnt = found ? (4'b0001 << win) : 4'b0000;

  // Capture the winner into the write-port registers and move priority to
  // the port just after the winner. Without a transfer only the write enable
  // drops; the last address/data/select stay visible and ptr is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 2'd0;
      sel     <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (found) begin
      ptr     <= win + 2'd1;
      sel     <= win;
      wr_addr <= addr_arr[win];
      wr_data <= data_arr[win];
      wr_en   <= (addr_arr[win] != '0);
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
//
// Self-checking bench for regfile_wr_arbiter. Directed steps cover reset,
// round robin, wrap/skip, the $zero register, stall and a lone requester,
// followed by a randomized phase with protocol-obeying requesters. A
// behavioural model of the priority rules supplies every expected value.

module tb_regfile_wr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic [3:0]        req;
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int                m_ptr;
  int                m_sel;
  logic              m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;

  int wait_cnt [4];

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .req     (req),
    .addr0   (addr_arr[0]),
    .addr1   (addr_arr[1]),
    .addr2   (addr_arr[2]),
    .addr3   (addr_arr[3]),
    .data0   (data_arr[0]),
    .data1   (data_arr[1]),
    .data2   (data_arr[2]),
    .data3   (data_arr[3]),
    .gnt     (gnt),
    .sel     (sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] r);
    stall = s;
    req   = r;
  endtask

  // Index of the requester the priority rules select, or -1 for none.
  function automatic int modelWinner();
    if (!rst_n || stall) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_ptr     = 0;
    m_sel     = 0;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  // One clock cycle: inputs were set after the falling edge. Checks the
  // combinational grant, advances the model at the rising edge, checks the
  // registered outputs just after it, and returns at the next falling edge.
  task automatic runCycle(input string tag, output int won);
    int w;
    logic [3:0] eg;
    #1;
    w  = modelWinner();
    eg = (w < 0) ? 4'b0000 : 4'(1 << w);
    checkOutput({tag, "_gnt"}, 64'(gnt), 64'(eg));
    @(posedge clk);
    if (w >= 0) begin
      m_sel     = w;
      m_wr_addr = addr_arr[w];
      m_wr_data = data_arr[w];
      m_wr_en   = (addr_arr[w] != 0);
      m_ptr     = (w + 1) % 4;
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
    checkOutput({tag, "_sel"},     64'(sel),     64'(m_sel));
    checkOutput({tag, "_wr_en"},   64'(wr_en),   64'(m_wr_en));
    checkOutput({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'(m_wr_data));
    @(negedge clk);
    won = w;
  endtask

  initial begin
    int won;
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      addr_arr[i] = ADDR_W'(i + 1);
      data_arr[i] = 32'h1000 + i;
      wait_cnt[i] = 0;
    end
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 4'b1111);
    #1;
    checkOutput("rst_gnt",     64'(gnt),     64'(4'b0000));
    checkOutput("rst_wr_en",   64'(wr_en),   64'(1'b0));
    checkOutput("rst_sel",     64'(sel),     64'(2'd0));
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'(0));
    checkOutput("rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with all four requesting
    #1;
    checkOutput("rr_first_gnt", 64'(gnt), 64'(4'b0001));
    for (int i = 0; i < 8; i++) begin
      runCycle("rr", won);
      checkOutput("rr_order", 64'(won), 64'(i % 4));
    end

    // Wrap and skip: last grant was port 3
    applyStimulus(1'b0, 4'b0101);
    runCycle("wrap0", won); checkOutput("wrap_first",  64'(won), 64'(0));
    runCycle("wrap1", won); checkOutput("wrap_second", 64'(won), 64'(2));
    runCycle("wrap2", won); checkOutput("wrap_third",  64'(won), 64'(0));

    // Reset mid-transfer, no clock edge involved
    applyStimulus(1'b0, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_gnt",     64'(gnt),     64'(4'b0000));
    checkOutput("midrst_wr_en",   64'(wr_en),   64'(1'b0));
    checkOutput("midrst_sel",     64'(sel),     64'(2'd0));
    checkOutput("midrst_wr_addr", 64'(wr_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_gnt", 64'(gnt), 64'(4'b0001));
    runCycle("postrst", won);

    // $zero register: grant happens, write is suppressed, ptr advances
    addr_arr[1] = '0;
    data_arr[1] = 32'hDEADBEEF;
    applyStimulus(1'b0, 4'b0010);
    runCycle("zero", won);
    checkOutput("zero_won",     64'(won),     64'(1));
    checkOutput("zero_wr_en",   64'(wr_en),   64'(1'b0));
    checkOutput("zero_wr_addr", 64'(wr_addr), 64'(0));
    checkOutput("zero_wr_data", 64'(wr_data), 64'(32'hDEADBEEF));
    checkOutput("zero_sel",     64'(sel),     64'(2'd1));
    applyStimulus(1'b0, 4'b0011);
    runCycle("zero_ptr", won);
    checkOutput("zero_ptr_adv", 64'(won), 64'(0));

    // Stall freezes arbitration
    addr_arr[1] = 5'd9;
    applyStimulus(1'b1, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      runCycle("stall", won);
      checkOutput("stall_gnt0",  64'(gnt),   64'(4'b0000));
      checkOutput("stall_wr_en", 64'(wr_en), 64'(1'b0));
    end
    applyStimulus(1'b0, 4'b0110);
    runCycle("unstall0", won); checkOutput("unstall_first",  64'(won), 64'(1));
    runCycle("unstall1", won); checkOutput("unstall_second", 64'(won), 64'(2));

    // Lone requester granted every cycle
    addr_arr[3] = 5'd7;
    applyStimulus(1'b0, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      data_arr[3] = DATA_W'(i);
      runCycle("single", won);
      checkOutput("single_won",     64'(won),     64'(3));
      checkOutput("single_wr_data", 64'(wr_data), 64'(i));
      checkOutput("single_wr_en",   64'(wr_en),   64'(1'b1));
    end

    // Randomized requesters obeying hold-until-grant
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && ($urandom_range(0, 2) != 0)) begin
          req[i]      = 1'b1;
          addr_arr[i] = ADDR_W'($urandom_range(0, 7) == 0 ? 0 : $urandom);
          data_arr[i] = $urandom;
          wait_cnt[i] = 0;
        end
      end
      stall = ($urandom_range(0, 9) == 0);
      runCycle("rand", won);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && i != won && !stall) wait_cnt[i]++;
      end
      if (won >= 0) begin
        checkOutput("rand_fair", 64'(wait_cnt[won] <= 3), 64'(1));
        if ($urandom_range(0, 1) == 0) begin
          req[won] = 1'b0;
        end else begin
          addr_arr[won] = ADDR_W'($urandom);
          data_arr[won] = $urandom;
          wait_cnt[won] = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
